// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM state encoding and
// the default operand width.
package serial_add_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder built from two half-adder stages; the single shared
// arithmetic cell of the serial adder.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic c
);

    logic h_sum;
    logic g_xy;
    logic g_ci;

    assign h_sum = x ^ y;
    assign g_xy  = x & y;
    assign s     = h_sum ^ ci;
    assign g_ci  = h_sum & ci;
    assign c     = g_xy | g_ci;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: adds a + b + cin one bit per clock, LSB first,
// through a single fa_cell, with a start/busy/done handshake and held results.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sh_a_q, sh_a_d;
    logic [WIDTH-1:0]   sh_b_q, sh_b_d;
    // Only the upper WIDTH-1 partial-sum bits need storage; the newest bit
    // comes straight from the adder cell on the final edge.
    logic [WIDTH-2:0]   sh_s_q, sh_s_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic               fa_s;
    logic               fa_c;
    logic [WIDTH-1:0]   s_shift;

    fa_cell u_fa_cell (
        .x  (sh_a_q[0]),
        .y  (sh_b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .c  (fa_c)
    );

    assign s_shift = {fa_s, sh_s_q};

    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        sh_s_d  = sh_s_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sh_a_d  = a;
                    sh_b_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sh_s_d  = s_shift[WIDTH-1:1];
                sh_a_d  = {1'b0, sh_a_q[WIDTH-1:1]};
                sh_b_d  = {1'b0, sh_b_q[WIDTH-1:1]};
                carry_d = fa_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    sum_d   = s_shift;
                    cout_d  = fa_c;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            sh_s_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            sh_s_q  <= sh_s_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int errors = 0;
    int checks = 0;

    // Last result the bench expects the DUT to be holding.
    logic [WIDTH-1:0] prev_sum  = '0;
    logic             prev_cout = 1'b0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] op_a,
                          input logic [WIDTH-1:0] op_b, input logic op_cin,
                          input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
        int busy_cycles = 0;
        int dones = 0;
        int unstable = 0;
        a = op_a;
        b = op_b;
        cin = op_cin;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = ~op_a;
        b = '0;
        cin = ~op_cin;
        for (int i = 0; i < 20 && dones == 0; i++) begin
            if (busy) begin
                busy_cycles++;
                if (sum !== prev_sum || cout !== prev_cout) unstable++;
            end
            if (done) dones++;
            else tick();
        end
        check_eq({tag, " busy_cycles"}, 32'(busy_cycles), 32'd8);
        check_eq({tag, " done_seen"}, 32'(dones), 32'd1);
        check_eq({tag, " held_while_busy"}, 32'(unstable), 32'd0);
        check_eq({tag, " sum"}, 32'(sum), 32'(exp_sum));
        check_eq({tag, " cout"}, 32'(cout), 32'(exp_cout));
        tick();
        check_eq({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check_eq({tag, " idle_after"}, 32'(busy), 32'd0);
        prev_sum  = exp_sum;
        prev_cout = exp_cout;
    endtask

    initial begin
        int dones;
        int unstable;
        int first_done;
        int last_done;

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_eq("reset busy", 32'(busy), 32'd0);
        check_eq("reset done", 32'(done), 32'd0);
        check_eq("reset sum", 32'(sum), 32'd0);
        check_eq("reset cout", 32'(cout), 32'd0);
        tick();
        check_eq("idle no start", 32'(busy), 32'd0);

        run_op("5a+3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        run_op("ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op("ff+ff+1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        run_op("00+00+1", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
        run_op("a5+5a", 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0);

        // start pulses during RUN and DONE must be ignored
        a = 8'h10;
        b = 8'h20;
        cin = 1'b0;
        start = 1'b1;
        tick();
        dones = 0;
        unstable = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            start = (cyc == 3 || cyc == 9);
            a = 8'h77;
            b = 8'h11;
            tick();
            if (done) dones++;
            if (busy && sum !== prev_sum) unstable++;
        end
        start = 1'b0;
        check_eq("ignore done_count", 32'(dones), 32'd1);
        check_eq("ignore held_while_busy", 32'(unstable), 32'd0);
        check_eq("ignore sum", 32'(sum), 32'h30);
        check_eq("ignore cout", 32'(cout), 32'd0);
        check_eq("ignore not requeued", 32'(busy), 32'd0);
        prev_sum = 8'h30;
        prev_cout = 1'b0;

        // start held high: one accept every WIDTH+2 cycles
        a = 8'h01;
        b = 8'h01;
        cin = 1'b0;
        start = 1'b1;
        dones = 0;
        first_done = -1;
        last_done = -1;
        for (int e = 0; e < 30; e++) begin
            tick();
            if (done) begin
                if (dones == 0) first_done = e;
                else check_eq("held period", 32'(e - last_done), 32'd10);
                check_eq("held sum", 32'(sum), 32'h02);
                last_done = e;
                dones++;
            end
        end
        start = 1'b0;
        check_eq("held done_count", 32'(dones), 32'd3);
        check_eq("held first_done", 32'(first_done), 32'd8);
        tick();
        tick();
        check_eq("held stop", 32'(busy), 32'd0);

        // reset in the middle of an operation
        a = 8'h5A;
        b = 8'h3C;
        cin = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check_eq("midrst busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst busy", 32'(busy), 32'd0);
        check_eq("midrst done", 32'(done), 32'd0);
        check_eq("midrst sum", 32'(sum), 32'd0);
        check_eq("midrst cout", 32'(cout), 32'd0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) dones++;
        end
        check_eq("midrst no_done", 32'(dones), 32'd0);
        prev_sum = '0;
        prev_cout = 1'b0;
        run_op("after rst", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);

        // rst beats start in IDLE
        rst = 1'b1;
        start = 1'b1;
        tick();
        check_eq("rst+start busy", 32'(busy), 32'd0);
        rst = 1'b0;
        start = 1'b0;
        tick();
        check_eq("rst+start stays idle", 32'(busy), 32'd0);
        check_eq("rst+start sum", 32'(sum), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
